tdm_deinterleaver: RTL

//  Receive end of the round-robin TDM path: takes one time-multiplexed word stream
//  (slot 0..NUM_CHANNELS-1, slot 0 flagged by din_sof) and rebuilds aligned per-channel frames.

---
 rtl/tdm_pkg.sv | 10 +
 rtl/sat_counter.sv | 19 +
 rtl/tdm_deinterleaver.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM definitions: receive-side state encoding and the default frame geometry
// used by both the TX multiplexer and the RX deinterleaver.
package tdm_pkg;

  typedef enum logic {HUNT, LOCKED} tdm_rx_state_t;

  localparam int TDM_DATA_WIDTH   = 8;
  localparam int TDM_NUM_CHANNELS = 2;

endpackage : tdm_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/tdm_deinterleaver.sv
// Rebuilds aligned per-channel frames from a round-robin TDM word stream, tracking
// slot-0 alignment and counting framing errors.
module tdm_deinterleaver
  import tdm_pkg::*;
#(
  parameter int DATA_WIDTH    = TDM_DATA_WIDTH,
  parameter int NUM_CHANNELS  = TDM_NUM_CHANNELS,
  parameter int GAP_TIMEOUT   = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 din_valid,
  input  logic                                 din_sof,
  input  logic [DATA_WIDTH-1:0]                din_data,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   dout_data,
  output logic                                 dout_valid,
  output logic                                 locked,
  output logic [ERR_CNT_WIDTH-1:0]             err_cnt
);

  localparam int SLOT_W = $clog2(NUM_CHANNELS);
  localparam int GAP_W  = $clog2(GAP_TIMEOUT + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CHANNELS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);

  tdm_rx_state_t     state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              store_en;
  logic [SLOT_W-1:0] store_slot;
  logic              frame_done;
  logic              err_inc;

  // Slots 0..N-2 only; the final slot is taken straight from din_data.
  logic [NUM_CHANNELS-2:0][DATA_WIDTH-1:0] asm_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    slot_d     = slot_q;
    gap_d      = gap_q;
    store_en   = 1'b0;
    store_slot = slot_q;
    frame_done = 1'b0;
    err_inc    = 1'b0;

    if (din_valid) begin
      gap_d = '0;
      unique case (state_q)
        HUNT: begin
          if (din_sof) begin
            store_en   = 1'b1;
            store_slot = '0;
            slot_d     = SLOT_W'(1);
            state_d    = LOCKED;
          end
        end
        LOCKED: begin
          if (din_sof) begin
            // A sof on slot 0 is normal; anywhere else it restarts the frame.
            err_inc    = (slot_q != '0);
            store_en   = 1'b1;
            store_slot = '0;
            slot_d     = SLOT_W'(1);
          end else if (slot_q == '0) begin
            err_inc = 1'b1;
            state_d = HUNT;
          end else if (slot_q == SLOT_LAST) begin
            frame_done = 1'b1;
            slot_d     = '0;
          end else begin
            store_en = 1'b1;
            slot_d   = slot_q + SLOT_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end else if ((state_q == LOCKED) && (slot_q != '0)) begin
      if (gap_q == GAP_LAST) begin
        err_inc = 1'b1;
        state_d = HUNT;
        slot_d  = '0;
        gap_d   = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      gap_q      <= '0;
      dout_data  <= '0;
      dout_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      gap_q      <= gap_d;
      dout_valid <= frame_done;
      if (frame_done) begin
        dout_data <= {din_data, asm_q};
      end
    end
  end

  // NOTE: the assembly buffer is not reset; its contents only reach dout_data after
  // every slot of a frame has been rewritten, so stale words are never visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS - 1; i++) begin
      if (store_en && (store_slot == SLOT_W'(i))) begin
        asm_q[i] <= din_data;
      end
    end
  end

  assign locked = (state_q == LOCKED);

  sat_counter #(
    .WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_cnt)
  );

endmodule : tdm_deinterleaver
